// File: rtl/bsg_manycore_link_credit_adapter.sv
// ----------------------------------------------------------------------------
// bsg_manycore_link_credit_adapter
//
// Purpose:
//   Converts credit-based, valid-only manycore return-path links into
//   ready/valid streams. Each channel owns a packet FIFO of els_p entries
//   (equal to the credits granted to the sender). Every dequeued packet
//   returns exactly one credit pulse credit_delay_p cycles later.
//   Channels are fully independent.
//
// Optional feature macro:
//   BSG_MANYCORE_CREDIT_ADAPTER_BYPASS_EN
//     defined   : an empty FIFO forwards v_i/data_i combinationally to
//                 v_o/data_o, and a packet taken in that same cycle is never
//                 written into the FIFO (it still returns a credit).
//     undefined : outputs depend only on registered state (1-cycle latency).
//
// Ports:
//   clk_i        in   clock
//   reset_n_i    in   asynchronous active-low reset
//   v_i          in   [num_links_p]          credit-side packet valid
//   data_i       in   [num_links_p*width_p]  credit-side packet data
//   credit_o     out  [num_links_p]          one-cycle credit pulse per dequeue
//   v_o          out  [num_links_p]          ready/valid side: packet available
//   data_o       out  [num_links_p*width_p]  ready/valid side: head packet
//   ready_and_i  in   [num_links_p]          consumer ready
//   count_o      out  [num_links_p*count_w]  FIFO occupancy per channel
//   overflow_o   out  [num_links_p]          sticky: packet arrived with no space
// ----------------------------------------------------------------------------
module bsg_manycore_link_credit_adapter #(
    parameter int width_p        = 32,
    parameter int num_links_p    = 1,
    parameter int els_p          = 3,
    parameter int credit_delay_p = 1,
    localparam int count_w_lp    = $clog2(els_p + 1)
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [num_links_p-1:0]            v_i,
    input  logic [num_links_p*width_p-1:0]    data_i,
    output logic [num_links_p-1:0]            credit_o,
    output logic [num_links_p-1:0]            v_o,
    output logic [num_links_p*width_p-1:0]    data_o,
    input  logic [num_links_p-1:0]            ready_and_i,
    output logic [num_links_p*count_w_lp-1:0] count_o,
    output logic [num_links_p-1:0]            overflow_o
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [ptr_w_lp-1:0]   LAST_PTR = ptr_w_lp'(els_p - 1);
    localparam logic [count_w_lp-1:0] FULL_CNT = count_w_lp'(els_p);

    // Pointers wrap at els_p explicitly so non-power-of-2 depths work.
    function automatic logic [ptr_w_lp-1:0] f_ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    for (genvar c = 0; c < num_links_p; c++) begin : g_ch
        logic [width_p-1:0]        r_mem [els_p];
        logic [ptr_w_lp-1:0]       r_wr_ptr;
        logic [ptr_w_lp-1:0]       r_rd_ptr;
        logic [count_w_lp-1:0]     r_count;
        logic                      r_overflow;
        logic [credit_delay_p-1:0] r_credit_sr;

        logic               w_v_in;
        logic               w_ready;
        logic [width_p-1:0] w_data_in;
        logic [width_p-1:0] w_head;
        logic               w_empty;
        logic               w_full;
        logic               w_pop;
        logic               w_bypass;
        logic               w_deq;
        logic               w_enq;
        logic               w_drop;

        assign w_v_in    = v_i[c];
        assign w_ready   = ready_and_i[c];
        assign w_data_in = data_i[c*width_p +: width_p];
        assign w_head    = r_mem[r_rd_ptr];

        // Full/empty come from the occupancy counter, never from pointers.
        assign w_empty = (r_count == '0);
        assign w_full  = (r_count == FULL_CNT);
        assign w_pop   = ~w_empty & w_ready;

`ifdef BSG_MANYCORE_CREDIT_ADAPTER_BYPASS_EN
        // Forwarding is gated by reset so outputs still clear at once.
        assign w_bypass = w_empty & w_v_in & w_ready & reset_n_i;
        assign v_o[c]   = ~w_empty | (w_v_in & reset_n_i);
        assign data_o[c*width_p +: width_p] = w_empty ? w_data_in : w_head;
`else
        assign w_bypass = 1'b0;
        assign v_o[c]   = ~w_empty;
        assign data_o[c*width_p +: width_p] = w_head;
`endif

        // A bypassed packet counts as a dequeue for credit purposes.
        assign w_deq  = w_pop | w_bypass;
        // Full is still acceptable when the head leaves in the same cycle.
        assign w_enq  = w_v_in & ~w_bypass & (~w_full | w_pop);
        assign w_drop = w_v_in & ~w_bypass & ~w_enq;

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_overflow  <= 1'b0;
                r_credit_sr <= '0;
            end else begin
                if (w_enq) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
                if (w_pop) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
                r_count     <= r_count + count_w_lp'(w_enq) - count_w_lp'(w_pop);
                if (w_drop) r_overflow <= 1'b1;
                // Bit k holds a dequeue from k+1 cycles ago.
                r_credit_sr <= (r_credit_sr << 1) | credit_delay_p'(w_deq);
            end
        end

        // Packet storage carries no reset; validity is tracked by r_count.
        always_ff @(posedge clk_i) begin
            if (w_enq) r_mem[r_wr_ptr] <= w_data_in;
        end

        assign credit_o[c]                          = r_credit_sr[credit_delay_p-1];
        assign count_o[c*count_w_lp +: count_w_lp] = r_count;
        assign overflow_o[c]                        = r_overflow;
    end

endmodule
